// File: rtl/nrisc_ula_pkg.sv
// Shared opcodes and flag bit positions for the NRISC ULA.
package nrisc_ula_pkg;

  // Opcodes decoded from ULA_ctrl; bit 3 only matters for shift/rotate codes.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_RTR = 4'b1101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_RTL = 4'b1110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

endpackage

// File: rtl/nrisc_ula_shifter.sv
// Single-bit shift/rotate unit for the ULA; also returns the bit shifted out.
module nrisc_ula_shifter #(
  parameter int TAM = 16
) (
  input  logic [TAM-1:0] a_i,
  input  logic           rot_i,
  input  logic           left_i,
  output logic [TAM-1:0] res_o,
  output logic           shout_o
);

  always_comb begin
    if (left_i) begin
      res_o   = {a_i[TAM-2:0], rot_i ? a_i[TAM-1] : 1'b0};
      shout_o = a_i[TAM-1];
    end else begin
      res_o   = {rot_i ? a_i[0] : 1'b0, a_i[TAM-1:1]};
      shout_o = a_i[0];
    end
  end

endmodule

// File: rtl/nrisc_ula.sv
// NRISC 16-bit ULA: combinational result, registered Z/N/C flags.
// Define NRISC_ULA_FLAGS_COMB_EN to drive ULA_flags straight from the next-flag logic.
module nrisc_ula
  import nrisc_ula_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic           incdec,
  input  logic           cmp2,
  input  logic [3:0]     ULA_ctrl,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags
);

  logic [TAM-1:0] bop;
  logic [TAM:0]   sum, diff;
  logic           lt_s;
  logic [TAM-1:0] sh_res;
  logic           sh_out;
  logic           carry;
  logic [2:0]     flags_d;

  assign bop  = incdec ? {{(TAM-1){1'b0}}, 1'b1} : ULA_B;
  assign sum  = {1'b0, ULA_A} + {1'b0, bop};
  // MSB of the widened difference is the unsigned borrow.
  assign diff = {1'b0, ULA_A} - {1'b0, bop};
  assign lt_s = $signed(ULA_A) < $signed(bop);

  nrisc_ula_shifter #(.TAM(TAM)) u_shifter (
    .a_i     (ULA_A),
    .rot_i   (ULA_ctrl[3]),
    .left_i  (ULA_ctrl[1]),
    .res_o   (sh_res),
    .shout_o (sh_out)
  );

  always_comb begin
    ULA_OUT = ~ULA_A;
    carry   = 1'b0;
    case (ULA_ctrl[2:0])
      OP_ADD[2:0]: begin ULA_OUT = sum[TAM-1:0];  carry = sum[TAM]; end
      OP_SUB[2:0]: begin ULA_OUT = diff[TAM-1:0]; carry = cmp2 ? lt_s : diff[TAM]; end
      OP_AND[2:0]: ULA_OUT = ULA_A & ULA_B;
      OP_OR[2:0]:  ULA_OUT = ULA_A | ULA_B;
      OP_XOR[2:0]: ULA_OUT = ULA_A ^ ULA_B;
      OP_SHR[2:0],
      OP_SHL[2:0]: begin ULA_OUT = sh_res; carry = sh_out; end
      default:     ULA_OUT = ~ULA_A;
    endcase
  end

  always_comb begin
    flags_d        = 3'b000;
    flags_d[FLG_Z] = (ULA_OUT == '0);
    flags_d[FLG_N] = ULA_OUT[TAM-1];
    flags_d[FLG_C] = carry;
  end

`ifdef NRISC_ULA_FLAGS_COMB_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign ULA_flags = flags_d;
`else
  logic [2:0] flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= 3'b000;
    else      flags_q <= flags_d;
  end

  assign ULA_flags = flags_q;
`endif

endmodule

// File: tb/tb_nrisc_ula.sv
// Directed-vector and random check of nrisc_ula result and registered flags.
module tb_nrisc_ula;

  logic        clk, rst;
  logic [15:0] a, b;
  logic        incdec, cmp2;
  logic [3:0]  ctrl;
  logic [15:0] out;
  logic [2:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  nrisc_ula #(.TAM(16)) dut (
    .clk(clk), .rst(rst), .ULA_A(a), .ULA_B(b), .incdec(incdec), .cmp2(cmp2),
    .ULA_ctrl(ctrl), .ULA_OUT(out), .ULA_flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  ctrl;
    logic        incdec, cmp2;
    logic [15:0] out;
    logic [2:0]  flg; // {C,N,Z}
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: returns {C,N,Z,result}
  function automatic logic [18:0] model(input logic [15:0] ma, mb, input logic [3:0] c,
                                        input logic inc, cp);
    logic [15:0] r, op2;
    logic        cy;
    op2 = inc ? 16'd1 : mb;
    cy  = 1'b0;
    if (c[2:0] == 3'd0) begin
      r  = ma + op2;
      cy = (32'(ma) + 32'(op2)) > 32'hFFFF;
    end else if (c[2:0] == 3'd1) begin
      r  = ma - op2;
      cy = cp ? (int'($signed(ma)) < int'($signed(op2))) : (ma < op2);
    end else if (c[2:0] == 3'd2) r = ma & mb;
    else if (c[2:0] == 3'd3) r = ma | mb;
    else if (c[2:0] == 3'd4) r = ma ^ mb;
    else if (c[2:0] == 3'd5) begin
      r  = (ma >> 1) | (c[3] ? {ma[0], 15'd0} : 16'd0);
      cy = ma[0];
    end else if (c[2:0] == 3'd6) begin
      r  = (ma << 1) | (c[3] ? {15'd0, ma[15]} : 16'd0);
      cy = ma[15];
    end else r = ~ma;
    return {cy, r[15], r == 16'd0, r};
  endfunction

  task automatic apply(input vec_t v);
    a = v.a; b = v.b; ctrl = v.ctrl; incdec = v.incdec; cmp2 = v.cmp2;
  endtask

  initial begin
    vt[0]  = '{16'hFFFF, 16'h0001, 4'b0000, 0, 0, 16'h0000, 3'b101};
    vt[1]  = '{16'h0003, 16'h0005, 4'b0001, 0, 0, 16'hFFFE, 3'b110};
    vt[2]  = '{16'h8000, 16'h0001, 4'b0001, 0, 1, 16'h7FFF, 3'b100};
    vt[3]  = '{16'h8000, 16'h0001, 4'b0001, 0, 0, 16'h7FFF, 3'b000};
    vt[4]  = '{16'h00FF, 16'h1234, 4'b0000, 1, 0, 16'h0100, 3'b000};
    vt[5]  = '{16'h00FF, 16'h1234, 4'b0001, 1, 0, 16'h00FE, 3'b000};
    vt[6]  = '{16'h8001, 16'hAAAA, 4'b0101, 0, 0, 16'h4000, 3'b100};
    vt[7]  = '{16'h8001, 16'hAAAA, 4'b1101, 0, 0, 16'hC000, 3'b110};
    vt[8]  = '{16'h8001, 16'hAAAA, 4'b0110, 0, 0, 16'h0002, 3'b100};
    vt[9]  = '{16'h8001, 16'hAAAA, 4'b1110, 0, 0, 16'h0003, 3'b100};
    vt[10] = '{16'hF0F0, 16'h0FF0, 4'b0010, 0, 0, 16'h00F0, 3'b000};
    vt[11] = '{16'hF0F0, 16'h0FF0, 4'b0011, 0, 0, 16'hFFF0, 3'b010};
    vt[12] = '{16'hF0F0, 16'h0FF0, 4'b0100, 0, 0, 16'hFF00, 3'b010};
    vt[13] = '{16'hF0F0, 16'h0FF0, 4'b0111, 0, 0, 16'h0F0F, 3'b000};
    vt[14] = '{16'hF0F0, 16'h0FF0, 4'b1111, 0, 0, 16'h0F0F, 3'b000};
    vt[15] = '{16'h1234, 16'h1111, 4'b1000, 0, 0, 16'h2345, 3'b000};
    vt[16] = '{16'hF0F0, 16'h0FF0, 4'b1010, 0, 0, 16'h00F0, 3'b000};
    vt[17] = '{16'h00FF, 16'h1234, 4'b0010, 1, 0, 16'h0034, 3'b000};
    vt[18] = '{16'h0005, 16'h0005, 4'b0001, 0, 0, 16'h0000, 3'b001};
    vt[19] = '{16'h0001, 16'h8000, 4'b1001, 0, 1, 16'h8001, 3'b010};

    a = 0; b = 0; ctrl = 0; incdec = 0; cmp2 = 0;
    rst = 1'b0;
    #3 chk("reset_flags", 32'(flags), 32'h0);
    @(posedge clk); #1 chk("reset_hold", 32'(flags), 32'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk) apply(vt[i]);
      #1 chk($sformatf("out[%0d]", i), 32'(out), 32'(vt[i].out));
      @(posedge clk); #1 chk($sformatf("flags[%0d]", i), 32'(flags), 32'(vt[i].flg));
    end

    // Flags must not update before the edge.
    @(negedge clk) apply(vt[0]);
    #1 chk("pre_edge_flags", 32'(flags), 32'(vt[19].flg));
    @(posedge clk); #1 chk("edge_flags", 32'(flags), 32'h5);

    // Asynchronous reset mid-cycle, result path keeps tracking.
    @(negedge clk); #2 rst = 1'b0;
    #1 chk("async_rst_flags", 32'(flags), 32'h0);
    apply(vt[1]);
    #1 chk("out_during_rst", 32'(out), 32'hFFFE);
    @(posedge clk); #1 chk("rst_held_flags", 32'(flags), 32'h0);
    #2 rst = 1'b1;
    #1 chk("rst_release_no_edge", 32'(flags), 32'h0);
    @(posedge clk); #1 chk("rst_release_reload", 32'(flags), 32'h6);

    for (int i = 0; i < 300; i++) begin
      logic [18:0] e;
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); ctrl = 4'($urandom);
      incdec = ($urandom_range(0, 3) == 0); cmp2 = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      e = model(a, b, ctrl, incdec, cmp2);
      #1 chk($sformatf("rnd_out[%0d]", i), 32'(out), 32'(e[15:0]));
      @(posedge clk); #1 chk($sformatf("rnd_flags[%0d]", i), 32'(flags), 32'(e[18:16]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
